// File: rtl/text_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | text_buf_pkg : shared types and constants for the LCD line-buffer writer |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package text_buf_pkg;

  localparam int         LINE_LEN = 16;
  localparam int         COL_W    = $clog2(LINE_LEN);
  localparam logic [8:0] BLANK    = 9'h120;

  typedef enum logic [1:0] {
    KK_CHAR  = 2'b00,
    KK_BKSP  = 2'b01,
    KK_ENTER = 2'b10,
    KK_CLEAR = 2'b11
  } key_kind_e;

  typedef enum logic [1:0] {
    ST_CLR  = 2'd0,
    ST_IDLE = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  typedef struct packed {
    logic             line;
    logic [COL_W-1:0] col;
  } cursor_t;

endpackage
`default_nettype wire

// File: rtl/text_cursor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | text_cursor : next-cursor logic for advance (CHAR), back (BKSP), newline |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module text_cursor #(
  parameter int LINE_LEN = 16
) (
  input  text_buf_pkg::cursor_t   cur,
  input  text_buf_pkg::key_kind_e op,
  output text_buf_pkg::cursor_t   nxt
);
  import text_buf_pkg::*;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);

  always_comb begin
    nxt = cur;
    case (op)
      KK_CHAR: begin
        // Column wraps into the other line; line 2 wraps back to line 1.
        if (cur.col == COL_LAST) begin
          nxt.col  = '0;
          nxt.line = ~cur.line;
        end else begin
          nxt.col = cur.col + COL_W'(1);
        end
      end
      KK_BKSP: begin
        if (cur.col != '0) begin
          nxt.col = cur.col - COL_W'(1);
        end else if (cur.line) begin
          nxt.line = 1'b0;
          nxt.col  = COL_LAST;
        end
      end
      KK_ENTER: begin
        nxt.line = ~cur.line;
        nxt.col  = '0;
      end
      default: nxt = cur;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/text_buf_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | text_buf_ctrl : key-event driven write controller for two LCD lines     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module text_buf_ctrl #(
  parameter int                LINE_LEN  = 16,
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 9,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [DATA_W-1:0] BLANK     = DATA_W'(text_buf_pkg::BLANK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [1:0]        key_kind,
  input  logic [7:0]        key_char,
  output logic              wr_en_1,
  output logic              wr_en_2,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cur_line,
  output logic [3:0]        cur_col,
  output logic              busy
);
  import text_buf_pkg::*;

  localparam int               IDX_W    = $clog2(2 * LINE_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * LINE_LEN - 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_clr_idx;
  logic             r_adv;
  cursor_t          w_cur;
  cursor_t          w_nxt;
  key_kind_e        w_op;

  assign w_cur = '{line: cur_line, col: cur_col};
  // The single cursor unit advances during WR and otherwise follows the key.
  assign w_op  = (r_state == ST_WR) ? KK_CHAR : key_kind_e'(key_kind);

  text_cursor #(.LINE_LEN(LINE_LEN)) u_cursor (
    .cur (w_cur),
    .op  (w_op),
    .nxt (w_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLR;
      r_clr_idx <= '0;
      r_adv     <= 1'b0;
      cur_line  <= 1'b0;
      cur_col   <= '0;
      wr_en_1   <= 1'b0;
      wr_en_2   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      key_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (r_state)
        ST_CLR: begin
          wr_en_1   <= ~r_clr_idx[IDX_W-1];
          wr_en_2   <= r_clr_idx[IDX_W-1];
          wr_addr   <= ADDR_BASE + ADDR_W'(r_clr_idx[IDX_W-2:0]);
          wr_data   <= BLANK;
          key_ready <= 1'b0;
          busy      <= 1'b1;
          r_clr_idx <= r_clr_idx + IDX_W'(1);
          if (r_clr_idx == IDX_LAST) begin
            r_state  <= ST_IDLE;
            cur_line <= 1'b0;
            cur_col  <= '0;
          end
        end
        ST_IDLE: begin
          wr_en_1   <= 1'b0;
          wr_en_2   <= 1'b0;
          key_ready <= 1'b1;
          busy      <= 1'b0;
          if (key_valid && key_ready) begin
            case (key_kind_e'(key_kind))
              KK_CHAR: begin
                // Strobe is registered here so it is live during the WR cycle.
                r_state   <= ST_WR;
                r_adv     <= 1'b1;
                wr_en_1   <= ~cur_line;
                wr_en_2   <= cur_line;
                wr_addr   <= ADDR_BASE + ADDR_W'(cur_col);
                wr_data   <= DATA_W'({1'b1, key_char});
                key_ready <= 1'b0;
                busy      <= 1'b1;
              end
              KK_BKSP: begin
                r_state   <= ST_WR;
                r_adv     <= 1'b0;
                cur_line  <= w_nxt.line;
                cur_col   <= w_nxt.col;
                wr_en_1   <= ~w_nxt.line;
                wr_en_2   <= w_nxt.line;
                wr_addr   <= ADDR_BASE + ADDR_W'(w_nxt.col);
                wr_data   <= BLANK;
                key_ready <= 1'b0;
                busy      <= 1'b1;
              end
              KK_ENTER: begin
                cur_line <= w_nxt.line;
                cur_col  <= w_nxt.col;
              end
              default: begin
                r_state   <= ST_CLR;
                r_clr_idx <= '0;
                key_ready <= 1'b0;
                busy      <= 1'b1;
              end
            endcase
          end
        end
        ST_WR: begin
          wr_en_1   <= 1'b0;
          wr_en_2   <= 1'b0;
          key_ready <= 1'b1;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
          if (r_adv) begin
            cur_line <= w_nxt.line;
            cur_col  <= w_nxt.col;
          end
        end
        default: begin
          r_state   <= ST_CLR;
          r_clr_idx <= '0;
          wr_en_1   <= 1'b0;
          wr_en_2   <= 1'b0;
          key_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_buf_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_text_buf_ctrl : randomized key stream against a linear-position model |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_text_buf_ctrl;

  localparam logic [8:0] BLANK_W = 9'h120;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic       key_ready;
  logic [1:0] key_kind;
  logic [7:0] key_char;
  logic       wr_en_1;
  logic       wr_en_2;
  logic [5:0] wr_addr;
  logic [8:0] wr_data;
  logic       cur_line;
  logic [3:0] cur_col;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  int pos      = 0;   // cursor as line*16+col
  logic [8:0] exp_mem [32];
  logic [8:0] obs_mem [32];

  text_buf_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_kind  (key_kind),
    .key_char  (key_char),
    .wr_en_1   (wr_en_1),
    .wr_en_2   (wr_en_2),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cur_line  (cur_line),
    .cur_col   (cur_col),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Capture every strobed write into a picture of both line memories.
  always @(posedge clk) begin
    #1;
    if (wr_en_1 === 1'b1 || wr_en_2 === 1'b1) begin
      wr_count++;
      check_eq("wr_excl_range", {29'd0, wr_en_1 & wr_en_2, wr_addr[5:4]}, 32'd0);
      obs_mem[{wr_en_2, wr_addr[3:0]}] = wr_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) exp_mem[i] = BLANK_W;
    pos = 0;
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (key_ready !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", {31'd0, key_ready}, 32'd1);
  endtask

  // Full 32-write blank sweep, with random key noise that must be ignored.
  task automatic sweep_check();
    for (int k = 1; k <= 33; k++) begin
      key_valid = (k < 32) ? 1'($urandom_range(0, 1)) : 1'b0;
      key_kind  = 2'($urandom);
      key_char  = 8'($urandom);
      @(negedge clk);
      if (k <= 32) begin
        check_eq("sweep_en", {30'd0, wr_en_1, wr_en_2}, (k <= 16) ? 32'd2 : 32'd1);
        check_eq("sweep_addr", {26'd0, wr_addr}, 32'((k - 1) % 16));
        check_eq("sweep_data", {23'd0, wr_data}, {23'd0, BLANK_W});
        check_eq("sweep_ready", {31'd0, key_ready}, 32'd0);
      end else begin
        check_eq("post_sweep_ready", {31'd0, key_ready}, 32'd1);
        check_eq("post_sweep_busy", {31'd0, busy}, 32'd0);
        check_eq("post_sweep_cursor", {27'd0, cur_line, cur_col}, 32'd0);
      end
    end
    model_clear();
  endtask

  task automatic reset_sweep();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_wr_en", {30'd0, wr_en_1, wr_en_2}, 32'd0);
    check_eq("rst_ready", {31'd0, key_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    check_eq("rst_addr_data", {17'd0, wr_addr, wr_data}, 32'd0);
    check_eq("rst_cursor", {27'd0, cur_line, cur_col}, 32'd0);
    rst = 1'b0;
    sweep_check();
  endtask

  task automatic do_key(input logic [1:0] kind, input logic [7:0] ch);
    int w0;
    int idx;
    wait_ready(50);
    w0        = wr_count;
    key_valid = 1'b1;
    key_kind  = kind;
    key_char  = ch;
    @(negedge clk);
    key_valid = 1'b0;
    key_kind  = 2'($urandom);
    key_char  = 8'($urandom);
    case (kind)
      2'b00: begin
        idx          = pos;
        exp_mem[idx] = {1'b1, ch};
        pos          = (pos + 1) % 32;
        @(negedge clk);
        check_eq("char_nwr", wr_count - w0, 32'd1);
        check_eq("char_data", {23'd0, obs_mem[idx]}, {23'd0, exp_mem[idx]});
      end
      2'b01: begin
        if (pos > 0) pos = pos - 1;
        idx          = pos;
        exp_mem[idx] = BLANK_W;
        @(negedge clk);
        check_eq("bksp_nwr", wr_count - w0, 32'd1);
        check_eq("bksp_data", {23'd0, obs_mem[idx]}, {23'd0, exp_mem[idx]});
      end
      2'b10: begin
        pos = (pos < 16) ? 16 : 0;
        check_eq("enter_ready", {31'd0, key_ready}, 32'd1);
        check_eq("enter_nwr", wr_count - w0, 32'd0);
      end
      default: begin
        model_clear();
        wait_ready(40);
        check_eq("clear_nwr", wr_count - w0, 32'd32);
      end
    endcase
    check_eq("cursor", {27'd0, cur_line, cur_col}, pos);
  endtask

  task automatic check_all_mem();
    for (int i = 0; i < 32; i++)
      check_eq("mem", {23'd0, obs_mem[i]}, {23'd0, exp_mem[i]});
  endtask

  initial begin
    int w0;
    int n;
    int r;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_kind  = 2'd0;
    key_char  = 8'd0;
    @(negedge clk);
    reset_sweep();

    // 17 'A's fill line 1 and spill one into line 2.
    for (int i = 0; i < 17; i++) do_key(2'b00, 8'h41);
    check_all_mem();

    // Wrap from (1,15) back to (0,0).
    do_key(2'b11, 8'h00);
    do_key(2'b10, 8'h00);
    for (int i = 0; i < 15; i++) do_key(2'b00, 8'($urandom_range(32, 126)));
    do_key(2'b00, 8'h42);

    // Backspace across the line boundary and at the home position.
    do_key(2'b10, 8'h00);
    do_key(2'b01, 8'h00);
    do_key(2'b10, 8'h00);
    do_key(2'b10, 8'h00);
    do_key(2'b00, 8'h5A);
    do_key(2'b01, 8'h00);
    do_key(2'b01, 8'h00);

    // Two ENTERs on consecutive edges from (0,7).
    for (int i = 0; i < 7; i++) do_key(2'b00, 8'h30 + 8'(i));
    wait_ready(50);
    w0        = wr_count;
    key_valid = 1'b1;
    key_kind  = 2'b10;
    @(negedge clk);
    check_eq("enter2_first_cursor", {27'd0, cur_line, cur_col}, 32'd16);
    check_eq("enter2_ready", {31'd0, key_ready}, 32'd1);
    @(negedge clk);
    key_valid = 1'b0;
    pos       = 0;
    check_eq("enter2_second_cursor", {27'd0, cur_line, cur_col}, 32'd0);
    check_eq("enter2_nwr", wr_count - w0, 32'd0);
    check_all_mem();

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      do_key(2'b00, 8'($urandom));
      else if (r < 78) do_key(2'b01, 8'($urandom));
      else if (r < 95) do_key(2'b10, 8'($urandom));
      else             do_key(2'b11, 8'($urandom));
    end
    check_all_mem();

    // Reset in the middle of a CLEAR sweep restarts it from index 0.
    wait_ready(50);
    key_valid = 1'b1;
    key_kind  = 2'b11;
    @(negedge clk);
    key_valid = 1'b0;
    n = 0;
    while (!(wr_en_1 === 1'b1 && wr_addr == 6'd10) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("clr_idx10_seen", {31'd0, wr_en_1}, 32'd1);
    reset_sweep();
    check_all_mem();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
